// File: rtl/div_pkg.sv
// div_pkg: shared definitions for the iterative divide sequencer.
//   div_state_t      : sequencer FSM states
//   DIV_W..MOD_WU    : bit positions of the one-hot op vector
//   DIV_STEPS        : number of shift-subtract steps (one per result bit)
//   mag32/cond_neg32 : sign helpers used when preparing operands and fixing up results
package div_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PREP = 3'd1,
    S_CALC = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } div_state_t;

  localparam int DIV_W  = 0;
  localparam int MOD_W  = 1;
  localparam int DIV_WU = 2;
  localparam int MOD_WU = 3;

  localparam int DIV_STEPS = 32;

  // Magnitude of a value; only negative values of signed ops are negated.
  // 0x80000000 wraps to itself, which yields the defined overflow result.
  function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
    logic [31:0] m;
    if (is_signed && v[31]) begin
      m = ~v + 32'd1;
    end else begin
      m = v;
    end
    return m;
  endfunction

  // Two's-complement negate when neg is set.
  function automatic logic [31:0] cond_neg32(input logic [31:0] v, input logic neg);
    logic [31:0] r;
    if (neg) begin
      r = ~v + 32'd1;
    end else begin
      r = v;
    end
    return r;
  endfunction

endpackage

// File: rtl/div_core.sv
// div_core: one combinational radix-2 restoring division step.
//   rem, dvd : current partial remainder and dividend/quotient shift register
//   dsr      : divisor magnitude
//   rem_n    : next partial remainder
//   dvd_n    : dvd shifted left by one with the LSB left clear for qbit
//   qbit     : quotient bit produced by this step
module div_core
  import div_pkg::*;
(
  input  logic [31:0] rem,
  input  logic [31:0] dvd,
  input  logic [31:0] dsr,
  output logic [31:0] rem_n,
  output logic [31:0] dvd_n,
  output logic        qbit
);

  logic [31:0] sh_s;
  logic [31:0] trial_s;
  logic        ge_s;

  // Shift-subtract step. The shifted remainder is 33 bits wide; when its top
  // bit (rem[31]) is set it exceeds any 32-bit divisor, so the subtract always
  // succeeds and the true difference still fits in 32 bits.
  always_comb begin
    sh_s    = {rem[30:0], dvd[31]};
    ge_s    = rem[31] | (sh_s >= dsr);
    trial_s = sh_s - dsr;
    if (ge_s) begin
      rem_n = trial_s;
    end else begin
      rem_n = sh_s;
    end
    dvd_n = {dvd[30:0], 1'b0};
    qbit  = ge_s;
  end

endmodule

// File: rtl/div_seq.sv
// div_seq: iterative 32-bit divide sequencer (div.w, mod.w, div.wu, mod.wu).
// Radix-2 restoring division, one quotient bit per cycle, result held until consumed.
//   clk, reset (async, active-high)
//   in_valid/in_ready : op handshake (in_ready high in IDLE only)
//   op                : one-hot {mod_wu, div_wu, mod_w, div_w}
//   src1, src2        : dividend, divisor
//   flush             : cancels any op in flight, returns to IDLE next edge
//   busy              : high in PREP, CALC, FIX
//   out_valid/out_ready : result handshake (out_valid high in DONE)
//   result            : quotient or remainder, registered
// Optional macro DIV_ZERO_FASTPATH_EN: PREP short-cuts divide-by-zero straight to FIX
// with the same result the full iteration would produce.
module div_seq
  import div_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic            flush,
  output logic            busy,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result
);

  div_state_t      state_r;
  div_state_t      state_n;
  logic [3:0]      op_r;
  logic [XLEN-1:0] src1_r;
  logic [XLEN-1:0] src2_r;
  logic [XLEN-1:0] rem_r;
  logic [XLEN-1:0] dvd_r;
  logic [XLEN-1:0] dsr_r;
  logic            sq_r;
  logic            sr_r;
  logic [4:0]      cnt_r;
  logic [XLEN-1:0] result_r;

  logic [XLEN-1:0] rem_n_s;
  logic [XLEN-1:0] dvd_n_s;
  logic            qbit_s;
  logic            signed_s;
  logic            is_mod_s;

  assign signed_s = op_r[DIV_W] | op_r[MOD_W];
  assign is_mod_s = op_r[MOD_W] | op_r[MOD_WU];

  div_core u_core (
    .rem   (rem_r),
    .dvd   (dvd_r),
    .dsr   (dsr_r),
    .rem_n (rem_n_s),
    .dvd_n (dvd_n_s),
    .qbit  (qbit_s)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_n;
    end
  end

  // Next-state logic; flush overrides everything, including an accept.
  always_comb begin
    state_n = state_r;
    if (flush) begin
      state_n = S_IDLE;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (in_valid) begin
            state_n = S_PREP;
          end else begin
            state_n = S_IDLE;
          end
        end
        S_PREP: begin
`ifdef DIV_ZERO_FASTPATH_EN
          if (src2_r == 32'd0) begin
            state_n = S_FIX;
          end else begin
            state_n = S_CALC;
          end
`else
          state_n = S_CALC;
`endif
        end
        S_CALC: begin
          if (cnt_r == 5'd0) begin
            state_n = S_FIX;
          end else begin
            state_n = S_CALC;
          end
        end
        S_FIX: begin
          state_n = S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            state_n = S_IDLE;
          end else begin
            state_n = S_DONE;
          end
        end
        default: begin
          state_n = S_IDLE;
        end
      endcase
    end
  end

  // Operand latch, iteration datapath and result fix-up.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_r     <= 4'd0;
      src1_r   <= 32'd0;
      src2_r   <= 32'd0;
      rem_r    <= 32'd0;
      dvd_r    <= 32'd0;
      dsr_r    <= 32'd0;
      sq_r     <= 1'b0;
      sr_r     <= 1'b0;
      cnt_r    <= 5'd0;
      result_r <= 32'd0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (in_valid && !flush) begin
            op_r   <= op;
            src1_r <= src1;
            src2_r <= src2;
          end
        end
        S_PREP: begin
          sq_r  <= signed_s & (src1_r[31] ^ src2_r[31]);
          sr_r  <= signed_s & src1_r[31];
          dsr_r <= mag32(src2_r, signed_s);
          cnt_r <= 5'(DIV_STEPS - 1);
`ifdef DIV_ZERO_FASTPATH_EN
          // Preload exactly what 32 steps against a zero divisor would leave.
          if (src2_r == 32'd0) begin
            dvd_r <= 32'hFFFF_FFFF;
            rem_r <= mag32(src1_r, signed_s);
          end else begin
            dvd_r <= mag32(src1_r, signed_s);
            rem_r <= 32'd0;
          end
`else
          dvd_r <= mag32(src1_r, signed_s);
          rem_r <= 32'd0;
`endif
        end
        S_CALC: begin
          rem_r <= rem_n_s;
          // dvd_n leaves its LSB clear; the new quotient bit fills it.
          dvd_r <= dvd_n_s | {31'd0, qbit_s};
          if (cnt_r != 5'd0) begin
            cnt_r <= cnt_r - 5'd1;
          end
        end
        S_FIX: begin
          if (is_mod_s) begin
            result_r <= cond_neg32(rem_r, sr_r);
          end else begin
            result_r <= cond_neg32(dvd_r, sq_r);
          end
        end
        S_DONE: begin
          result_r <= result_r;
        end
        default: begin
          result_r <= result_r;
        end
      endcase
    end
  end

  assign in_ready  = (state_r == S_IDLE);
  assign busy      = (state_r == S_PREP) || (state_r == S_CALC) || (state_r == S_FIX);
  assign out_valid = (state_r == S_DONE);
  assign result    = result_r;

endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq: directed self-checking bench for div_seq.
// Each step applies one op, measures the accept-to-out_valid latency and
// compares latency and result against hand-computed values.
module tb_div_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  op;
  logic [31:0] src1;
  logic [31:0] src2;
  logic        flush;
  logic        busy;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;

  int vectors = 0;
  int miscompares = 0;

  localparam logic [3:0] OP_DIV_W  = 4'b0001;
  localparam logic [3:0] OP_MOD_W  = 4'b0010;
  localparam logic [3:0] OP_DIV_WU = 4'b0100;
  localparam logic [3:0] OP_MOD_WU = 4'b1000;

`ifdef DIV_ZERO_FASTPATH_EN
  localparam int ZLAT = 3;
`else
  localparam int ZLAT = 35;
`endif

  div_seq #(.XLEN(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .src1      (src1),
    .src2      (src2),
    .flush     (flush),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Accept one op, wait (bounded) for out_valid, check latency/result,
  // optionally hold out_ready low for 'hold' cycles, then consume.
  task automatic run_op(input string tag, input logic [3:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res,
                        input int exp_lat, input int hold);
    int lat;
    @(negedge clk);
    in_valid = 1'b1; op = o; src1 = a; src2 = b;
    @(posedge clk);
    #1 in_valid = 1'b0;
    check({tag, "_busy"}, 32'(busy), 32'd1);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_res"}, result, exp_res);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, "_hold_res"}, result, exp_res);
      check({tag, "_hold_vld"}, 32'(out_valid), 32'd1);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check({tag, "_idle"}, 32'(in_ready), 32'd1);
    check({tag, "_vld_low"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    int seen;
    reset = 1'b1; in_valid = 1'b0; op = 4'd0; src1 = 32'd0; src2 = 32'd0;
    flush = 1'b0; out_ready = 1'b0;
    #12;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result", result, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    run_op("divw_100_7",   OP_DIV_W,  32'd100,        32'd7,          32'd14,         35, 0);
    run_op("modw_100_7",   OP_MOD_W,  32'd100,        32'd7,          32'd2,          35, 0);
    run_op("divw_m7_2",    OP_DIV_W,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  35, 0);
    run_op("modw_m7_2",    OP_MOD_W,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  35, 0);
    run_op("divwu_big_16", OP_DIV_WU, 32'hFFFF_FFFF,  32'h0000_0010,  32'h0FFF_FFFF,  35, 0);
    run_op("modwu_big_16", OP_MOD_WU, 32'hFFFF_FFFF,  32'h0000_0010,  32'h0000_000F,  35, 0);
    run_op("divw_ovf",     OP_DIV_W,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  35, 0);
    run_op("modw_ovf",     OP_MOD_W,  32'h8000_0000,  32'hFFFF_FFFF,  32'h0000_0000,  35, 0);
    run_op("divwu_5_0",    OP_DIV_WU, 32'd5,          32'd0,          32'hFFFF_FFFF,  ZLAT, 0);
    run_op("modwu_5_0",    OP_MOD_WU, 32'd5,          32'd0,          32'd5,          ZLAT, 0);
    run_op("modw_m5_0",    OP_MOD_W,  32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFB,  ZLAT, 0);
    run_op("divw_hold",    OP_DIV_W,  32'd100,        32'd7,          32'd14,         35, 5);

    // Flush in cycle T+10: back in IDLE at T+11 and no result ever appears.
    @(negedge clk);
    in_valid = 1'b1; op = OP_DIV_W; src1 = 32'd1000; src2 = 32'd3;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("flush_busy_before", 32'(busy), 32'd1);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    check("flush_in_ready", 32'(in_ready), 32'd1);
    check("flush_busy_after", 32'(busy), 32'd0);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    check("flush_no_valid", 32'(seen), 32'd0);

    // Flush together with an accept: the op is dropped.
    @(negedge clk);
    in_valid = 1'b1; flush = 1'b1; op = OP_DIV_W; src1 = 32'd9; src2 = 32'd3;
    @(posedge clk);
    #1 in_valid = 1'b0; flush = 1'b0;
    check("flush_wins_ready", 32'(in_ready), 32'd1);
    check("flush_wins_busy", 32'(busy), 32'd0);

    // Async reset mid-operation clears the result register and state.
    @(negedge clk);
    in_valid = 1'b1; op = OP_DIV_WU; src1 = 32'd50; src2 = 32'd5;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    check("arst_in_ready", 32'(in_ready), 32'd1);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_result", result, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Sequencer is usable again after the reset.
    run_op("divwu_50_5",   OP_DIV_WU, 32'd50,         32'd5,          32'd10,         35, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
